// File: rtl/ntt_mdc_pkg.sv
// Shared types and elaboration-time helpers for the MDC NTT pipeline
// scheduler and stage wrappers.
package ntt_mdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Width of the free-running timestamp counter: wide enough that the
    // modular age of any in-flight job stays unambiguous.
    function automatic int ts_width(input int lat_fntt, input int lat_intt, input int half);
        int lat_max;
        lat_max = (lat_fntt > lat_intt) ? lat_fntt : lat_intt;
        return $clog2(lat_max + half) + 2;
    endfunction

    // Pipeline latency from per-stage delays; inverse mode adds the
    // divide-by-two register delay in every stage.
    function automatic int calc_lat(input int logn, input int stage_delay,
                                    input int div2_delay, input bit inv);
        return logn * stage_delay + (inv ? logn * div2_delay : 0);
    endfunction

endpackage

// File: rtl/ntt_job_tracker.sv
// In-flight job tracker: timestamp FIFO of first-beat times plus the
// output window counter that frames out_valid/out_last at the pipeline tail.
module ntt_job_tracker
    import ntt_mdc_pkg::*;
#(
    parameter int HALF     = 128,
    parameter int LAT_FNTT = 64,
    parameter int LAT_INTT = 72,
    parameter int MAX_JOBS = 4,
    parameter int TS_W     = ts_width(LAT_FNTT, LAT_INTT, HALF),
    parameter int CNT_W    = $clog2(MAX_JOBS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             intt,
    input  logic [TS_W-1:0]  now,
    output logic             out_valid,
    output logic             out_last,
    output logic [CNT_W-1:0] jobs_inflight
);

    localparam int PTR_W  = $clog2(MAX_JOBS);
    localparam int BEAT_W = $clog2(HALF);

    logic [TS_W-1:0]   ts_mem [MAX_JOBS];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              win_active;
    logic [BEAT_W-1:0] win_cnt;
    logic [TS_W-1:0]   lat_sel;
    logic [TS_W-1:0]   age;
    logic              win_start;

    assign lat_sel       = intt ? TS_W'(LAT_INTT) : TS_W'(LAT_FNTT);
    assign age           = now - ts_mem[rd_ptr];
    assign win_start     = (count != '0) && !win_active && (age == lat_sel);
    assign out_valid     = win_active || win_start;
    assign out_last      = win_active && (win_cnt == BEAT_W'(HALF - 1));
    assign jobs_inflight = count;

    // Timestamp storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            ts_mem[wr_ptr] <= now;
    end

    // FIFO pointers, occupancy and the output window counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            win_active <= 1'b0;
            win_cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (out_last)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, out_last})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (win_start) begin
                win_active <= 1'b1;
                win_cnt    <= BEAT_W'(1);
            end else if (win_active) begin
                if (win_cnt == BEAT_W'(HALF - 1)) begin
                    win_active <= 1'b0;
                    win_cnt    <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ntt_mdc_sched.sv
// Job scheduler for the LOGN-stage MDC NTT pipeline: accepts jobs, gates
// the coefficient stream into stage 0, holds the pipeline mode constant
// while jobs are in flight and frames the tail output.
// Optional: define NTT_SCHED_PERF_EN for perf_jobs/perf_busy_cycles.
module ntt_mdc_sched
    import ntt_mdc_pkg::*;
#(
    parameter int LOGN     = 8,
    parameter int LAT_FNTT = 64,
    parameter int LAT_INTT = 72,
    parameter int MAX_JOBS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         job_valid,
    input  logic                         job_intt,
    output logic                         job_ready,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         stage_start,
    output logic                         intt,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         job_done,
    output logic                         busy,
    output logic [$clog2(MAX_JOBS):0]    jobs_inflight,
`ifdef NTT_SCHED_PERF_EN
    output logic [31:0]                  perf_jobs,
    output logic [31:0]                  perf_busy_cycles,
`endif
    output logic                         proto_err
);

    localparam int HALF   = 2 ** (LOGN - 1);
    localparam int BEAT_W = LOGN - 1;
    localparam int TS_W   = ts_width(LAT_FNTT, LAT_INTT, HALF);
    localparam int CNT_W  = $clog2(MAX_JOBS) + 1;

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [TS_W-1:0]   now;
    logic              last_beat;
    logic              mode_ok;
    logic              accept;
    logic              push;

    assign last_beat   = (beat_cnt == BEAT_W'(HALF - 1));
    assign mode_ok     = (jobs_inflight < CNT_W'(MAX_JOBS)) &&
                         ((jobs_inflight == '0) || (job_intt == intt));
    assign stage_start = in_ready && in_valid;
    assign push        = stage_start && (beat_cnt == '0);
    assign busy        = (state != IDLE) || (jobs_inflight != '0);
    assign job_done    = out_last;

    // Next state and handshake outputs; a same-mode job may be accepted on
    // the last load beat so back-to-back jobs stream without a gap.
    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        in_ready  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                job_ready = mode_ok;
                if (job_valid && mode_ok) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end else if (job_valid && (jobs_inflight != '0) && (job_intt != intt)) begin
                    state_nxt = DRAIN;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    job_ready = mode_ok;
                    if (job_valid && mode_ok)
                        accept = 1'b1;
                    else
                        state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (jobs_inflight == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            job_ready = 1'b0;
            in_ready  = 1'b0;
            accept    = 1'b0;
        end
    end

    // State register, beat counter, timestamp clock, mode and sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            now       <= '0;
            intt      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            now   <= now + 1'b1;
            if (accept)
                intt <= job_intt;
            if (stage_start)
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if ((state == LOAD) && !in_valid)
                proto_err <= 1'b1;
        end
    end

    ntt_job_tracker #(
        .HALF     (HALF),
        .LAT_FNTT (LAT_FNTT),
        .LAT_INTT (LAT_INTT),
        .MAX_JOBS (MAX_JOBS),
        .TS_W     (TS_W),
        .CNT_W    (CNT_W)
    ) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .intt          (intt),
        .now           (now),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .jobs_inflight (jobs_inflight)
    );

`ifdef NTT_SCHED_PERF_EN
    // Saturating counters of completed jobs and busy cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_jobs        <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (out_last && (perf_jobs != '1))
                perf_jobs <= perf_jobs + 1'b1;
            if (busy && (perf_busy_cycles != '1))
                perf_busy_cycles <= perf_busy_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_mdc_sched.sv
// Self-checking bench for ntt_mdc_sched: directed scenarios plus random job
// traffic, compared every cycle against a timestamp-based reference model.
module tb_ntt_mdc_sched;

    localparam int LOGN  = 4;
    localparam int HALF  = 8;
    localparam int LAT_F = 20;
    localparam int LAT_I = 22;
    localparam int MAXJ  = 2;

    localparam int ST_IDLE  = 0;
    localparam int ST_LOAD  = 1;
    localparam int ST_DRAIN = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       job_valid = 1'b0;
    logic       job_intt = 1'b0;
    logic       in_valid = 1'b1;
    logic       job_ready, in_ready, stage_start, intt;
    logic       out_valid, out_last, job_done, busy, proto_err;
    logic [1:0] jobs_inflight;
`ifdef NTT_SCHED_PERF_EN
    logic [31:0] perf_jobs, perf_busy_cycles;
`endif

    int  n_cmp = 0;
    int  n_err = 0;
    int  tb_cyc = 0;
    bit  chk_en = 0;

    int  m_state = ST_IDLE;
    bit  m_intt = 0;
    int  m_beats = 0;
    int  q[$];
    bit  m_err = 0;
    bit  m_undef = 0;
    int  m_jobs = 0;
    int  m_busy = 0;

    ntt_mdc_sched #(
        .LOGN     (LOGN),
        .LAT_FNTT (LAT_F),
        .LAT_INTT (LAT_I),
        .MAX_JOBS (MAXJ)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .job_valid     (job_valid),
        .job_intt      (job_intt),
        .job_ready     (job_ready),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .stage_start   (stage_start),
        .intt          (intt),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .job_done      (job_done),
        .busy          (busy),
        .jobs_inflight (jobs_inflight),
`ifdef NTT_SCHED_PERF_EN
        .perf_jobs        (perf_jobs),
        .perf_busy_cycles (perf_busy_cycles),
`endif
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, tb_cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic jv, input logic ji, input logic iv);
        @(posedge clk);
        #1;
        rst       = r;
        job_valid = jv;
        job_intt  = ji;
        in_valid  = iv;
        @(negedge clk);
    endtask

    // Reference model: jobs are remembered only by the cycle of their first
    // beat; output windows follow from that plus the mode latency.
    always @(negedge clk) begin
        int lat, sz;
        bit e_ir, e_ss, e_last, e_ok, e_jr, e_ov, e_ol, e_busy, acc;
        sz     = q.size();
        lat    = m_intt ? LAT_I : LAT_F;
        e_ir   = rst && (m_state == ST_LOAD);
        e_ss   = e_ir && in_valid;
        e_last = e_ss && (m_beats == HALF - 1);
        e_ok   = (sz < MAXJ) && (sz == 0 || job_intt == m_intt);
        e_jr   = rst && (m_state == ST_IDLE || e_last) && e_ok;
        e_ov   = 0;
        foreach (q[i])
            if (tb_cyc - q[i] >= lat && tb_cyc - q[i] <= lat + HALF - 1) e_ov = 1;
        e_ol   = (sz != 0) ? (tb_cyc - q[0] == lat + HALF - 1) : 0;
        e_busy = (m_state != ST_IDLE) || (sz != 0);
        if (chk_en) begin
            checkOutput("proto_err", proto_err, m_err);
            if (!m_undef) begin
                checkOutput("job_ready", job_ready, e_jr);
                checkOutput("in_ready", in_ready, e_ir);
                checkOutput("stage_start", stage_start, e_ss);
                checkOutput("intt", intt, m_intt);
                checkOutput("out_valid", out_valid, e_ov);
                checkOutput("out_last", out_last, e_ol);
                checkOutput("job_done", job_done, e_ol);
                checkOutput("busy", busy, e_busy);
                checkOutput("jobs_inflight", jobs_inflight, sz);
`ifdef NTT_SCHED_PERF_EN
                checkOutput("perf_jobs", perf_jobs, m_jobs);
                checkOutput("perf_busy_cycles", perf_busy_cycles, m_busy);
`endif
            end
        end
        if (!rst) begin
            m_state = ST_IDLE; m_intt = 0; m_beats = 0; q.delete();
            m_err = 0; m_undef = 0; m_jobs = 0; m_busy = 0;
        end else begin
            acc = job_valid && e_jr;
            if (e_busy) m_busy++;
            if (e_ol) begin m_jobs++; void'(q.pop_front()); end
            if (m_state == ST_LOAD && !in_valid) begin m_err = 1; m_undef = 1; end
            if (e_ss) begin
                if (m_beats == 0) q.push_back(tb_cyc);
                m_beats = (m_beats + 1) % HALF;
            end
            case (m_state)
                ST_IDLE: begin
                    if (acc) begin m_intt = job_intt; m_state = ST_LOAD; end
                    else if (job_valid && sz != 0 && job_intt != m_intt) m_state = ST_DRAIN;
                end
                ST_LOAD: begin
                    if (e_last) begin
                        if (acc) m_intt = job_intt;
                        else m_state = ST_IDLE;
                    end
                end
                default: if (sz == 0) m_state = ST_IDLE;
            endcase
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            applyStimulus(1, 0, 0, 1);
            n++;
        end
        if (busy !== 1'b0) checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic singleJob();
        int acc, fs, ns, fv, nv, lc, fall;
        fs = -1; ns = 0; fv = -1; nv = 0; lc = -1; fall = -1;
        applyStimulus(1, 1, 0, 1);
        acc = tb_cyc;
        checkOutput("sj_accept", job_ready, 1);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 0, 0, 1);
            if (stage_start) begin if (fs < 0) fs = tb_cyc; ns++; end
            if (out_valid) begin if (fv < 0) fv = tb_cyc; nv++; end
            if (out_last) lc = tb_cyc;
            if (!busy && fall < 0) fall = tb_cyc;
        end
        checkOutput("sj_first_start", fs - acc, 1);
        checkOutput("sj_starts", ns, 8);
        checkOutput("sj_first_valid", fv - acc, 21);
        checkOutput("sj_valid_beats", nv, 8);
        checkOutput("sj_last", lc - acc, 28);
        checkOutput("sj_busy_fall", fall - acc, 29);
    endtask

    task automatic backToBack();
        int nacc, ns, maxinf, first_last, third_acc, n;
        nacc = 0; ns = 0; maxinf = 0; first_last = -1; third_acc = -1; n = 0;
        while (nacc < 3 && n < 200) begin
            applyStimulus(1, 1, 0, 1);
            if (stage_start) ns++;
            if (jobs_inflight > maxinf) maxinf = jobs_inflight;
            if (out_last && first_last < 0) first_last = tb_cyc;
            if (job_ready) begin nacc++; if (nacc == 3) third_acc = tb_cyc; end
            n++;
        end
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1, 0, 0, 1);
            if (stage_start) ns++;
            if (jobs_inflight > maxinf) maxinf = jobs_inflight;
            if (out_last && first_last < 0) first_last = tb_cyc;
        end
        checkOutput("b2b_accepts", nacc, 3);
        checkOutput("b2b_starts", ns, 24);
        checkOutput("b2b_max_inflight", maxinf, 2);
        checkOutput("b2b_third_after_free", third_acc - first_last, 1);
    endtask

    task automatic modeSwitch();
        int fwd_last, inv_acc, flip, inv_start, inv_ov, n;
        fwd_last = -1; inv_acc = -1; flip = -1; inv_start = -1; inv_ov = -1; n = 0;
        applyStimulus(1, 1, 0, 1);
        checkOutput("ms_fwd_accept", job_ready, 1);
        while (inv_acc < 0 && n < 200) begin
            applyStimulus(1, 1, 1, 1);
            if (out_last && fwd_last < 0) fwd_last = tb_cyc;
            if (job_ready) inv_acc = tb_cyc;
            n++;
        end
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1, 0, 0, 1);
            if (intt && flip < 0) flip = tb_cyc;
            if (intt && stage_start && inv_start < 0) inv_start = tb_cyc;
            if (intt && out_valid && inv_ov < 0) inv_ov = tb_cyc;
        end
        checkOutput("ms_accept_after_drain", inv_acc - fwd_last, 2);
        checkOutput("ms_intt_flip", flip - inv_acc, 1);
        checkOutput("ms_inv_latency", inv_ov - inv_start, 22);
    endtask

    task automatic bubble();
        int acc, ns, ls;
        ns = 0; ls = -1;
        applyStimulus(1, 1, 0, 1);
        acc = tb_cyc;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1, 0, 0, (i == 4) ? 1'b0 : 1'b1);
            if (stage_start) begin ns++; ls = tb_cyc; end
            if (i == 4) checkOutput("bub_no_start", stage_start, 0);
        end
        checkOutput("bub_starts", ns, 8);
        checkOutput("bub_last_start", ls - acc, 9);
        checkOutput("bub_err_sticky", proto_err, 1);
    endtask

    task automatic resetMid();
        applyStimulus(1, 1, 1, 1);
        checkOutput("rm_accept", job_ready, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("rm_in_ready", in_ready, 0);
        checkOutput("rm_stage_start", stage_start, 0);
        checkOutput("rm_intt", intt, 0);
        checkOutput("rm_out_valid", out_valid, 0);
        checkOutput("rm_out_last", out_last, 0);
        checkOutput("rm_inflight", jobs_inflight, 0);
        checkOutput("rm_busy", busy, 0);
        checkOutput("rm_proto_err", proto_err, 0);
    endtask

    initial begin
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        chk_en = 1;
        applyStimulus(1, 0, 0, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_intt", intt, 0);
        checkOutput("reset_inflight", jobs_inflight, 0);

        singleJob();
        waitIdle();
        backToBack();
        waitIdle();
        modeSwitch();
        waitIdle();

        for (int i = 0; i < 600; i++)
            applyStimulus(1, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1);
        waitIdle();

        bubble();
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        resetMid();
        singleJob();
`ifdef NTT_SCHED_PERF_EN
        checkOutput("perf_jobs_single", perf_jobs, 1);
`endif
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
